uart_frame_ctrl: RTL and testbench
==================================

# uart_frame_ctrl

Frame sequencer for the UART receive path. It turns the per-byte strobe from the UART receiver into framed messages using an idle-gap watchdog timer. After an `arm` command it waits for the first byte under a first-byte timeout, counts bytes, and declares end-of-frame when the line stays idle for a programmable gap. It sits between the UART RX byte stream and the packet/command parser, and owns the watchdog timer it sequences.

## Interface
Parameters:
- `LEN_W`, default 16: width of the frame length counter.
- `MAX_LEN`, default 256: frame length limit. Used only when `UART_FRAME_LEN_LIMIT_EN` is defined.

Ports:
- `clk`, in, 1: single clock for the block.
- `rst`, in, 1: reset, synchronous and active-high.
- `arm`, in, 1: one-cycle pulse that starts waiting for a frame.
- `abort`, in, 1: forces a return to IDLE. Highest priority.
- `auto_rearm`, in, 1: when 1, a completed frame or timeout re-enters WAIT_FIRST instead of IDLE.
- `cfg_first_timeout`, in, 32: first-byte timeout in cycles. 0 means wait forever.
- `cfg_gap`, in, 32: inter-frame idle gap in cycles. 0 is treated as 1.
- `rx_valid`, in, 1: one-cycle strobe, one per received byte.
- `busy`, out, 1: high in any state other than IDLE.
- `frame_start`, out, 1: pulse on the first byte of a frame.
- `frame_end`, out, 1: pulse when the gap expires.
- `frame_len`, out, `LEN_W`: byte count. Valid while `frame_end` is high and held until the next `frame_start`.
- `frame_err`, out, 1: qualifies `frame_end`; high means the frame overflowed.
- `timeout`, out, 1: pulse when the first-byte timeout expires.

## Operation
- States: IDLE, WAIT_FIRST, IN_FRAME, DRAIN. DRAIN exists only when `UART_FRAME_LEN_LIMIT_EN` is defined.
- IDLE:
  - `arm` goes to WAIT_FIRST and loads the timer with `cfg_first_timeout`.
  - `rx_valid` in IDLE is ignored.
- WAIT_FIRST:
  - `rx_valid` goes to IN_FRAME, pulses `frame_start`, sets `frame_len` to 1, clears `frame_err`, and loads the timer with the gap.
  - Timer expiry pulses `timeout`, then goes to IDLE, or reloads WAIT_FIRST if `auto_rearm` is set.
- IN_FRAME:
  - `rx_valid` increments `frame_len` (saturating at all-ones) and reloads the timer with the gap.
  - Timer expiry pulses `frame_end`, then goes to IDLE or WAIT_FIRST according to `auto_rearm`.
- Priority per cycle:
  - `abort` beats everything else.
  - `rx_valid` beats timer expiry in the same cycle: the byte is counted, the timer reloads, and no end or timeout occurs.
  - `arm` outside IDLE is ignored.
- `abort` in any state: go to IDLE and stop the timer. No `frame_end` or `timeout` is issued; `frame_len` keeps its value.
- Config inputs are sampled only at timer load. Changing them mid-wait has no effect until the next load.

## Timing
- Reset values: `busy`=0, `frame_start`=0, `frame_end`=0, `frame_len`=0, `frame_err`=0, `timeout`=0, state IDLE, timer stopped.
- All outputs are registered.
- `frame_start` is asserted in cycle t+1 for `rx_valid` at cycle t.
- Gap expiry: the last `rx_valid` at cycle t produces `frame_end` at cycle t+G+1, where G = max(`cfg_gap`, 1).
- Timeout: `arm` at cycle t produces `timeout` at cycle t+T+1 when T > 0.
- Back-to-back `rx_valid` every cycle never expires the gap timer.
- `busy` rises the cycle after `arm`. It falls in the same cycle `frame_end`/`timeout` pulses, unless `auto_rearm` is set.
- A `rst` assertion mid-frame returns every output to its reset value on the next edge.

## Configuration
- Macro: `UART_FRAME_LEN_LIMIT_EN`.
- Defined:
  - An `rx_valid` arriving while `frame_len` equals `MAX_LEN` sets `frame_err`, is not counted, and moves the block to DRAIN.
  - DRAIN reloads the timer on each `rx_valid` without counting.
  - On expiry, DRAIN pulses `frame_end` with `frame_err`=1 and `frame_len`=`MAX_LEN`.
- Undefined:
  - No DRAIN state; `frame_err` is tied to 0.
  - The length counter only saturates.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum;
  - `UART_TMR_W` = 32;
  - the gap-clamp constant `UART_GAP_MIN` = 1.
- Sub-module `uart_gap_timer`: a down-counter with `load`, `preset`, `stop`, `expire` (one-cycle pulse) and `running`. Preset 0 with the infinite flag set never expires.
- The sequencer FSM and length counter live in `uart_frame_ctrl`.

## Test plan
- **Basic frame:** `cfg_gap`=10, `arm`, then 5 `rx_valid` spaced 4 cycles apart → one `frame_start`; `frame_end` exactly 11 cycles after the 5th byte with `frame_len`=5; `busy` back to 0.
- **First-byte timeout:** `cfg_first_timeout`=255, `arm`, no bytes → `timeout` exactly 256 cycles after `arm`; no `frame_start`. With `cfg_first_timeout`=0, no timeout after 10000 cycles.
- **Collision:** `rx_valid` on the exact cycle of gap expiry → no `frame_end` that cycle; `frame_len` increments; `frame_end` G+1 cycles later.
- **Abort and reset mid-frame:**
  - `abort` after 3 bytes → IDLE, no `frame_end`, `frame_len`=3.
  - `rst` after 3 bytes → all outputs zero.
- **Auto re-arm:** `auto_rearm`=1, two frames of 2 and 7 bytes separated by 50 idle cycles with `cfg_gap`=20 → two `frame_end` pulses with lengths 2 and 7; `busy` stays 1 throughout.
- **Length limit (macro defined):** `MAX_LEN`=4, 6 bytes → `frame_end` with `frame_err`=1 and `frame_len`=4. Same stimulus without the macro → `frame_len`=6, `frame_err`=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive frame sequencer.
// Define UART_FRAME_LEN_LIMIT_EN to enable the frame length limit and DRAIN state.
package uart_pkg;

    localparam int unsigned UART_TMR_W = 32;
    localparam logic [UART_TMR_W-1:0] UART_GAP_MIN = 1;

    typedef enum logic [1:0] {
        StIdle,
        StWaitFirst,
        StInFrame
`ifdef UART_FRAME_LEN_LIMIT_EN
        ,
        StDrain
`endif
    } uart_state_t;

endpackage

// File: rtl/uart_gap_timer.sv
// Down-counting watchdog; expire pulses for one cycle when the count runs out.
// A zero preset loaded with infinite set keeps the timer running without ever expiring.
module uart_gap_timer
    import uart_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  stop,
    input  logic                  infinite,
    input  logic [UART_TMR_W-1:0] preset,
    output logic                  expire,
    output logic                  running
);

    logic [UART_TMR_W-1:0] cnt_q;
    logic                  run_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (stop) begin
            run_q <= 1'b0;
        end else if (load) begin
            cnt_q <= preset;
            run_q <= (preset != '0) || infinite;
        end else if (run_q) begin
            if (cnt_q == UART_TMR_W'(1)) begin
                run_q <= 1'b0;
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - UART_TMR_W'(1);
            end
        end
    end

    // Expiry is seen during the last counted cycle so the owner can register its pulse.
    assign expire  = run_q && (cnt_q == UART_TMR_W'(1));
    assign running = run_q;

endmodule

// File: rtl/uart_frame_ctrl.sv
// Frame sequencer: frames the UART RX byte strobe using first-byte and idle-gap timeouts.
// Define UART_FRAME_LEN_LIMIT_EN to cap frames at MAX_LEN bytes and flag overflow.
module uart_frame_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned LEN_W   = 16,
    parameter int unsigned MAX_LEN = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  auto_rearm,
    input  logic [UART_TMR_W-1:0] cfg_first_timeout,
    input  logic [UART_TMR_W-1:0] cfg_gap,
    input  logic                  rx_valid,
    output logic                  busy,
    output logic                  frame_start,
    output logic                  frame_end,
    output logic [LEN_W-1:0]      frame_len,
    output logic                  frame_err,
    output logic                  timeout
);

    uart_state_t           state_q;
    logic                  tmr_load;
    logic                  tmr_inf;
    logic                  tmr_expire;
    logic                  tmr_running;
    logic [UART_TMR_W-1:0] tmr_preset;
    logic [UART_TMR_W-1:0] gap_eff;
    logic                  rearm_exit;

    assign gap_eff    = (cfg_gap < UART_GAP_MIN) ? UART_GAP_MIN : cfg_gap;
    assign rearm_exit = tmr_expire && auto_rearm;

    // Config is only sampled here, at the moment the timer loads.
    always_comb begin
        tmr_load   = 1'b0;
        tmr_preset = cfg_first_timeout;
        if (!abort) begin
            case (state_q)
                StIdle: tmr_load = arm;
                default: begin
                    if (rx_valid) begin
                        tmr_load   = 1'b1;
                        tmr_preset = gap_eff;
                    end else if (rearm_exit) begin
                        tmr_load = 1'b1;
                    end
                end
            endcase
        end
        tmr_inf = (tmr_preset == '0);
    end

    uart_gap_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .stop     (abort),
        .infinite (tmr_inf),
        .preset   (tmr_preset),
        .expire   (tmr_expire),
        .running  (tmr_running)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            busy        <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            frame_len   <= '0;
            frame_err   <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            timeout     <= 1'b0;
            if (abort) begin
                state_q <= StIdle;
                busy    <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (arm) begin
                            state_q <= StWaitFirst;
                            busy    <= 1'b1;
                        end
                    end
                    StWaitFirst: begin
                        if (rx_valid) begin
                            state_q     <= StInFrame;
                            frame_start <= 1'b1;
                            frame_len   <= LEN_W'(1);
                            frame_err   <= 1'b0;
                        end else if (tmr_expire) begin
                            timeout <= 1'b1;
                            state_q <= auto_rearm ? StWaitFirst : StIdle;
                            busy    <= auto_rearm;
                        end
                    end
                    StInFrame: begin
                        if (rx_valid) begin
`ifdef UART_FRAME_LEN_LIMIT_EN
                            if (frame_len == LEN_W'(MAX_LEN)) begin
                                frame_err <= 1'b1;
                                state_q   <= StDrain;
                            end else if (frame_len != '1) begin
                                frame_len <= frame_len + LEN_W'(1);
                            end
`else
                            if (frame_len != '1) begin
                                frame_len <= frame_len + LEN_W'(1);
                            end
`endif
                        end else if (tmr_expire) begin
                            frame_end <= 1'b1;
                            state_q   <= auto_rearm ? StWaitFirst : StIdle;
                            busy      <= auto_rearm;
                        end
                    end
`ifdef UART_FRAME_LEN_LIMIT_EN
                    StDrain: begin
                        // Excess bytes only keep the gap timer alive.
                        if (!rx_valid && tmr_expire) begin
                            frame_end <= 1'b1;
                            state_q   <= auto_rearm ? StWaitFirst : StIdle;
                            busy      <= auto_rearm;
                        end
                    end
`endif
                    default: begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Directed self-checking bench for uart_frame_ctrl; a second instance uses MAX_LEN=4.
module tb_uart_frame_ctrl;

    logic        clk;
    logic        rst;
    logic        arm;
    logic        abort;
    logic        auto_rearm;
    logic [31:0] cfg_first_timeout;
    logic [31:0] cfg_gap;
    logic        rx_valid;

    logic        busy, frame_start, frame_end, frame_err, timeout;
    logic [15:0] frame_len;
    logic        l_busy, l_frame_start, l_frame_end, l_frame_err, l_timeout;
    logic [15:0] l_frame_len;

    int total = 0;
    int bad   = 0;
    int start_cnt = 0;
    int end_cnt   = 0;
    int to_cnt    = 0;
    int end_lens[$];

    uart_frame_ctrl #(.LEN_W(16), .MAX_LEN(256)) dut (
        .clk               (clk),
        .rst               (rst),
        .arm               (arm),
        .abort             (abort),
        .auto_rearm        (auto_rearm),
        .cfg_first_timeout (cfg_first_timeout),
        .cfg_gap           (cfg_gap),
        .rx_valid          (rx_valid),
        .busy              (busy),
        .frame_start       (frame_start),
        .frame_end         (frame_end),
        .frame_len         (frame_len),
        .frame_err         (frame_err),
        .timeout           (timeout)
    );

    uart_frame_ctrl #(.LEN_W(16), .MAX_LEN(4)) dut_lim (
        .clk               (clk),
        .rst               (rst),
        .arm               (arm),
        .abort             (abort),
        .auto_rearm        (auto_rearm),
        .cfg_first_timeout (cfg_first_timeout),
        .cfg_gap           (cfg_gap),
        .rx_valid          (rx_valid),
        .busy              (l_busy),
        .frame_start       (l_frame_start),
        .frame_end         (l_frame_end),
        .frame_len         (l_frame_len),
        .frame_err         (l_frame_err),
        .timeout           (l_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (frame_start) start_cnt = start_cnt + 1;
        if (timeout) to_cnt = to_cnt + 1;
        if (frame_end) begin
            end_cnt = end_cnt + 1;
            end_lens.push_back(int'(frame_len));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic byte_pulse();
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic abort_pulse();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL reset_start got=%b exp=0", frame_start); end
        total++; if (frame_end !== 1'b0) begin bad++; $display("FAIL reset_end got=%b exp=0", frame_end); end
        total++; if (frame_len !== 16'd0) begin bad++; $display("FAIL reset_len got=%0d exp=0", frame_len); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", frame_err); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
        byte_pulse();
        total++; if (frame_start !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL idle_rx_ignored start=%b busy=%b exp=0,0", frame_start, busy);
        end
    endtask

    task automatic test_basic_frame();
        int s0;
        bit early;
        cfg_gap = 10; cfg_first_timeout = 0; auto_rearm = 1'b0;
        s0 = start_cnt;
        arm_pulse();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_rise got=%b exp=1", busy); end
        for (int i = 0; i < 5; i++) begin
            byte_pulse();
            if (i == 0) begin
                total++; if (frame_start !== 1'b1) begin bad++; $display("FAIL basic_start got=%b exp=1", frame_start); end
            end
            if (i < 4) repeat (3) tick();
        end
        early = 1'b0;
        for (int j = 1; j < 10; j++) begin
            tick();
            if (frame_end) early = 1'b1;
        end
        total++; if (early !== 1'b0) begin bad++; $display("FAIL basic_early_end got=1 exp=0"); end
        tick();
        total++; if (frame_end !== 1'b1) begin bad++; $display("FAIL basic_end got=%b exp=1", frame_end); end
        total++; if (frame_len !== 16'd5) begin bad++; $display("FAIL basic_len got=%0d exp=5", frame_len); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_fall got=%b exp=0", busy); end
        total++; if (start_cnt - s0 !== 1) begin bad++; $display("FAIL basic_start_count got=%0d exp=1", start_cnt - s0); end
        tick();
    endtask

    task automatic test_timeout();
        int s0;
        int t0;
        bit early;
        cfg_first_timeout = 255;
        s0 = start_cnt;
        arm_pulse();
        early = 1'b0;
        repeat (254) begin
            tick();
            if (timeout) early = 1'b1;
        end
        total++; if (early !== 1'b0) begin bad++; $display("FAIL timeout_early got=1 exp=0"); end
        tick();
        total++; if (timeout !== 1'b1) begin bad++; $display("FAIL timeout_pulse got=%b exp=1", timeout); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL timeout_busy got=%b exp=0", busy); end
        total++; if (start_cnt !== s0) begin bad++; $display("FAIL timeout_no_start got=%0d exp=%0d", start_cnt, s0); end
        tick();
        cfg_first_timeout = 0;
        t0 = to_cnt;
        arm_pulse();
        repeat (10000) tick();
        total++; if (to_cnt !== t0) begin bad++; $display("FAIL infinite_wait got=%0d exp=%0d", to_cnt, t0); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL infinite_busy got=%b exp=1", busy); end
        abort_pulse();
        tick();
    endtask

    task automatic test_collision();
        bit early;
        cfg_gap = 10;
        arm_pulse();
        byte_pulse();
        repeat (9) tick();
        byte_pulse();
        total++; if (frame_end !== 1'b0) begin bad++; $display("FAIL collide_no_end got=%b exp=0", frame_end); end
        total++; if (frame_len !== 16'd2) begin bad++; $display("FAIL collide_len got=%0d exp=2", frame_len); end
        early = 1'b0;
        repeat (9) begin
            tick();
            if (frame_end) early = 1'b1;
        end
        total++; if (early !== 1'b0) begin bad++; $display("FAIL collide_early got=1 exp=0"); end
        tick();
        total++; if (frame_end !== 1'b1) begin bad++; $display("FAIL collide_end got=%b exp=1", frame_end); end
        tick();
    endtask

    task automatic test_abort();
        int e0;
        int t0;
        cfg_gap = 10;
        arm_pulse();
        repeat (3) begin
            byte_pulse();
            tick();
        end
        abort_pulse();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
        total++; if (frame_len !== 16'd3) begin bad++; $display("FAIL abort_len got=%0d exp=3", frame_len); end
        e0 = end_cnt; t0 = to_cnt;
        repeat (20) tick();
        total++; if (end_cnt !== e0 || to_cnt !== t0) begin
            bad++; $display("FAIL abort_no_event ends=%0d tos=%0d exp=%0d,%0d", end_cnt, to_cnt, e0, t0);
        end
    endtask

    task automatic test_reset_mid_frame();
        arm_pulse();
        repeat (3) byte_pulse();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if ({busy, frame_start, frame_end, frame_err, timeout} !== 5'b0) begin
            bad++; $display("FAIL rst_mid_flags got=%b exp=00000", {busy, frame_start, frame_end, frame_err, timeout});
        end
        total++; if (frame_len !== 16'd0) begin bad++; $display("FAIL rst_mid_len got=%0d exp=0", frame_len); end
        tick();
    endtask

    task automatic test_auto_rearm();
        int busy_low;
        cfg_gap = 20; cfg_first_timeout = 0; auto_rearm = 1'b1;
        end_lens.delete();
        busy_low = 0;
        arm_pulse();
        repeat (2) begin
            byte_pulse();
            if (!busy) busy_low++;
        end
        repeat (50) begin
            tick();
            if (!busy) busy_low++;
        end
        repeat (7) begin
            byte_pulse();
            if (!busy) busy_low++;
        end
        repeat (50) begin
            tick();
            if (!busy) busy_low++;
        end
        total++; if (end_lens.size() !== 2) begin bad++; $display("FAIL rearm_end_count got=%0d exp=2", end_lens.size()); end
        if (end_lens.size() >= 2) begin
            total++; if (end_lens[0] !== 2) begin bad++; $display("FAIL rearm_len0 got=%0d exp=2", end_lens[0]); end
            total++; if (end_lens[1] !== 7) begin bad++; $display("FAIL rearm_len1 got=%0d exp=7", end_lens[1]); end
        end
        total++; if (busy_low !== 0) begin bad++; $display("FAIL rearm_busy_low got=%0d exp=0", busy_low); end
        auto_rearm = 1'b0;
        abort_pulse();
        tick();
    endtask

    task automatic test_len_limit();
        int exp_len;
        bit exp_err;
        bit seen;
`ifdef UART_FRAME_LEN_LIMIT_EN
        exp_len = 4; exp_err = 1'b1;
`else
        exp_len = 6; exp_err = 1'b0;
`endif
        cfg_gap = 10;
        arm_pulse();
        repeat (6) begin
            byte_pulse();
            tick();
        end
        seen = 1'b0;
        for (int i = 0; i < 15 && !seen; i++) begin
            if (l_frame_end) seen = 1'b1;
            else tick();
        end
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL limit_end_seen got=0 exp=1"); end
        total++; if (int'(l_frame_len) !== exp_len) begin bad++; $display("FAIL limit_len got=%0d exp=%0d", l_frame_len, exp_len); end
        total++; if (l_frame_err !== exp_err) begin bad++; $display("FAIL limit_err got=%b exp=%b", l_frame_err, exp_err); end
        total++; if (frame_len !== 16'd6 || frame_err !== 1'b0) begin
            bad++; $display("FAIL nolimit_len got=%0d err=%b exp=6,0", frame_len, frame_err);
        end
        tick();
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; abort = 1'b0; auto_rearm = 1'b0;
        cfg_first_timeout = 0; cfg_gap = 0; rx_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        test_reset();
        test_basic_frame();
        test_timeout();
        test_collision();
        test_abort();
        test_reset_mid_frame();
        test_auto_rearm();
        test_len_limit();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
